// File: rtl/vga_pkg.sv
// Shared timing types and helpers for the VGA timing generator.
// Holds the mode descriptor struct, two stock modes and total helpers.
package vga_pkg;

  localparam int SPAN_W = 14;
  typedef logic [SPAN_W-1:0] span_t;

  typedef struct packed {
    logic [11:0] hDisp;
    logic [11:0] hFront;
    logic [11:0] hSync;
    logic [11:0] hBack;
    logic [11:0] vDisp;
    logic [11:0] vFront;
    logic [11:0] vSync;
    logic [11:0] vBack;
    logic        hPol;
    logic        vPol;
  } vga_timing_t;

  localparam vga_timing_t SVGA_800x600_72 = '{
    hDisp:  12'd800,
    hFront: 12'd56,
    hSync:  12'd120,
    hBack:  12'd64,
    vDisp:  12'd600,
    vFront: 12'd37,
    vSync:  12'd6,
    vBack:  12'd23,
    hPol:   1'b1,
    vPol:   1'b1
  };

  localparam vga_timing_t VGA_640x480_60 = '{
    hDisp:  12'd640,
    hFront: 12'd16,
    hSync:  12'd96,
    hBack:  12'd48,
    vDisp:  12'd480,
    vFront: 12'd10,
    vSync:  12'd2,
    vBack:  12'd33,
    hPol:   1'b0,
    vPol:   1'b0
  };

  function automatic span_t hTotal(
    vga_timing_t t
  );
    return span_t'(t.hDisp)
      + span_t'(t.hFront)
      + span_t'(t.hSync)
      + span_t'(t.hBack);
  endfunction

  function automatic span_t vTotal(
    vga_timing_t t
  );
    return span_t'(t.vDisp)
      + span_t'(t.vFront)
      + span_t'(t.vSync)
      + span_t'(t.vBack);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the VGA raster: position counter.
// Ports: en/la_en, porch widths, pol; out wrap, next-state decode, lookahead.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         la_en,
  input  logic [11:0]  disp,
  input  logic [11:0]  front,
  input  logic [11:0]  sync,
  input  logic [11:0]  back,
  input  logic         pol,
  output logic         wrap,
  output logic         active_next,
  output logic         in_sync_next,
  output logic         pulse_next,
  output logic [W-1:0] la_count,
  output logic         la_active
);

  logic [W-1:0] count;
  logic [W-1:0] count_next;
  span_t        last;
  span_t        p_lo;
  span_t        p_hi;
  span_t        n_ext;
  logic         at_last;
  logic         last_next;

  // Wrap/advance kept apart from decode so that a pol
  // derived from wrap never forms a false comb loop.
  always_comb begin : adv
    last = span_t'(disp)
      + span_t'(front)
      + span_t'(sync)
      + span_t'(back)
      - span_t'(1);
    at_last = span_t'(count) == last;
    wrap = en && at_last;
    count_next = count;
    if (en) begin
      count_next = at_last ? '0 : count + W'(1);
    end
  end

  always_comb begin : decode
    p_lo = span_t'(disp) + span_t'(front);
    p_hi = p_lo + span_t'(sync);
    n_ext = span_t'(count_next);
    last_next = n_ext == last;
    active_next = n_ext < span_t'(disp);
    in_sync_next = (n_ext >= p_lo)
      && (n_ext < p_hi);
    pulse_next = in_sync_next ? pol : ~pol;
    la_count = count_next;
    if (la_en) begin
      la_count = last_next ? '0
        : count_next + W'(1);
    end
    la_active = span_t'(la_count)
      < span_t'(disp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Two-mode VGA timing generator: registered blank/sync pins, lookahead.
// Ports: Clock/Reset_n/PixelEn/Mode in; sync pins, nextX/Y, strobes out.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter vga_timing_t MODE0 = SVGA_800x600_72,
  parameter vga_timing_t MODE1 = VGA_640x480_60,
  parameter int X_WIDTH = 12,
  parameter int Y_WIDTH = 11
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               PixelEn,
  input  logic               Mode,
  output logic               blank_n,
  output logic               sync_n,
  output logic               hSync_n,
  output logic               vSync_n,
  output logic [X_WIDTH-1:0] nextX,
  output logic [Y_WIDTH-1:0] nextY,
  output logic               nextValid,
  output logic               lineStart,
  output logic               frameStart,
  output logic               activeMode
);

  if (int'(hTotal(MODE0)) > (1 << X_WIDTH))
  begin : g_chk_x0
    $error("MODE0 hTotal exceeds X_WIDTH");
  end
  if (int'(hTotal(MODE1)) > (1 << X_WIDTH))
  begin : g_chk_x1
    $error("MODE1 hTotal exceeds X_WIDTH");
  end
  if (int'(vTotal(MODE0)) > (1 << Y_WIDTH))
  begin : g_chk_y0
    $error("MODE0 vTotal exceeds Y_WIDTH");
  end
  if (int'(vTotal(MODE1)) > (1 << Y_WIDTH))
  begin : g_chk_y1
    $error("MODE1 vTotal exceeds Y_WIDTH");
  end

  logic [11:0] h_disp, h_front, h_sync, h_back;
  logic [11:0] v_disp, v_front, v_sync, v_back;
  logic        mode_next;
  logic        h_pol, v_pol;

  logic h_wrap, v_wrap;
  logic h_act, v_act;
  logic h_ins, v_ins;
  logic h_pulse, v_pulse;
  logic h_la_act, v_la_act;
  logic la_valid;
  logic v_la_en;

  logic [X_WIDTH-1:0] h_la;
  logic [Y_WIDTH-1:0] v_la;

  // Counters run on the current mode's widths;
  // the frame wrap lands on (0,0) in either mode.
  always_comb begin
    h_disp  = activeMode ? MODE1.hDisp  : MODE0.hDisp;
    h_front = activeMode ? MODE1.hFront : MODE0.hFront;
    h_sync  = activeMode ? MODE1.hSync  : MODE0.hSync;
    h_back  = activeMode ? MODE1.hBack  : MODE0.hBack;
    v_disp  = activeMode ? MODE1.vDisp  : MODE0.vDisp;
    v_front = activeMode ? MODE1.vFront : MODE0.vFront;
    v_sync  = activeMode ? MODE1.vSync  : MODE0.vSync;
    v_back  = activeMode ? MODE1.vBack  : MODE0.vBack;
  end

  // Mode is only taken on the final advance of a frame,
  // and the (0,0) pin levels already use its polarity.
  assign mode_next = v_wrap ? Mode : activeMode;
  assign h_pol = mode_next ? MODE1.hPol : MODE0.hPol;
  assign v_pol = mode_next ? MODE1.vPol : MODE0.vPol;

  // Horizontal lookahead wraps to 0 exactly when the
  // next position ends its line, so the row steps too.
  assign v_la_en = h_la == '0;
  assign la_valid = h_la_act && v_la_act;

  vga_axis_counter #(
    .W (X_WIDTH)
  ) u_h (
    .clk          (Clock),
    .rst_n        (Reset_n),
    .en           (PixelEn),
    .la_en        (1'b1),
    .disp         (h_disp),
    .front        (h_front),
    .sync         (h_sync),
    .back         (h_back),
    .pol          (h_pol),
    .wrap         (h_wrap),
    .active_next  (h_act),
    .in_sync_next (h_ins),
    .pulse_next   (h_pulse),
    .la_count     (h_la),
    .la_active    (h_la_act)
  );

  vga_axis_counter #(
    .W (Y_WIDTH)
  ) u_v (
    .clk          (Clock),
    .rst_n        (Reset_n),
    .en           (h_wrap),
    .la_en        (v_la_en),
    .disp         (v_disp),
    .front        (v_front),
    .sync         (v_sync),
    .back         (v_back),
    .pol          (v_pol),
    .wrap         (v_wrap),
    .active_next  (v_act),
    .in_sync_next (v_ins),
    .pulse_next   (v_pulse),
    .la_count     (v_la),
    .la_active    (v_la_act)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      activeMode <= 1'b0;
      blank_n    <= 1'b1;
      sync_n     <= 1'b1;
      hSync_n    <= ~MODE0.hPol;
      vSync_n    <= ~MODE0.vPol;
      nextX      <= X_WIDTH'(1);
      nextY      <= '0;
      nextValid  <= 1'b1;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      lineStart  <= h_wrap;
      frameStart <= v_wrap;
      if (PixelEn) begin
        activeMode <= mode_next;
        blank_n    <= h_act && v_act;
        sync_n     <= !(h_ins || v_ins);
        hSync_n    <= h_pulse;
        vSync_n    <= v_pulse;
        nextValid  <= la_valid;
        nextX      <= la_valid ? h_la : '0;
        nextY      <= la_valid ? v_la : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using two small custom modes.
// Reference model tracks raster position; monitor compares every edge.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int XW = 6;
  localparam int YW = 5;
  localparam int OW = 8 + XW + YW;

  localparam vga_timing_t T0 = '{
    hDisp: 12'd16, hFront: 12'd2,
    hSync: 12'd3, hBack: 12'd4,
    vDisp: 12'd6, vFront: 12'd1,
    vSync: 12'd2, vBack: 12'd2,
    hPol: 1'b1, vPol: 1'b1
  };
  localparam vga_timing_t T1 = '{
    hDisp: 12'd10, hFront: 12'd1,
    hSync: 12'd2, hBack: 12'd3,
    vDisp: 12'd4, vFront: 12'd1,
    vSync: 12'd1, vBack: 12'd2,
    hPol: 1'b0, vPol: 1'b0
  };

  typedef logic [OW-1:0] obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pen = 1'b0;
  logic mode = 1'b0;
  logic blank_n, sync_n, hSync_n, vSync_n;
  logic [XW-1:0] nextX;
  logic [YW-1:0] nextY;
  logic nextValid, lineStart;
  logic frameStart, activeMode;
  obs_t obs;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .MODE0   (T0),
    .MODE1   (T1),
    .X_WIDTH (XW),
    .Y_WIDTH (YW)
  ) dut (
    .Clock      (clk),
    .Reset_n    (rst_n),
    .PixelEn    (pen),
    .Mode       (mode),
    .blank_n    (blank_n),
    .sync_n     (sync_n),
    .hSync_n    (hSync_n),
    .vSync_n    (vSync_n),
    .nextX      (nextX),
    .nextY      (nextY),
    .nextValid  (nextValid),
    .lineStart  (lineStart),
    .frameStart (frameStart),
    .activeMode (activeMode)
  );

  assign obs = {blank_n, sync_n, hSync_n,
    vSync_n, nextX, nextY, nextValid,
    lineStart, frameStart, activeMode};

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  obs_t exp_q[$];
  int fs_times[$];

  int mh, mv, mm;
  bit mls, mfs;

  function automatic vga_timing_t tim(int m);
    return (m != 0) ? T1 : T0;
  endfunction

  function automatic int ht(int m);
    vga_timing_t t = tim(m);
    return int'(t.hDisp) + int'(t.hFront)
      + int'(t.hSync) + int'(t.hBack);
  endfunction

  function automatic int vt(int m);
    vga_timing_t t = tim(m);
    return int'(t.vDisp) + int'(t.vFront)
      + int'(t.vSync) + int'(t.vBack);
  endfunction

  localparam int F0 = 25 * 11;
  localparam int F1 = 16 * 8;

  function automatic obs_t model_out();
    vga_timing_t t = tim(mm);
    int hd = int'(t.hDisp);
    int vd = int'(t.vDisp);
    int hs0 = hd + int'(t.hFront);
    int vs0 = vd + int'(t.vFront);
    int hs1 = hs0 + int'(t.hSync);
    int vs1 = vs0 + int'(t.vSync);
    int nh = mh + 1;
    int nv = mv;
    bit act, hin, vin, hp, vp, nval;
    if (nh == ht(mm)) begin
      nh = 0;
      nv = mv + 1;
      if (nv == vt(mm)) nv = 0;
    end
    act = (mh < hd) && (mv < vd);
    hin = (mh >= hs0) && (mh < hs1);
    vin = (mv >= vs0) && (mv < vs1);
    hp = t.hPol ? hin : !hin;
    vp = t.vPol ? vin : !vin;
    nval = (nh < hd) && (nv < vd);
    return {act, !(hin || vin), hp, vp,
      nval ? XW'(nh) : XW'(0),
      nval ? YW'(nv) : YW'(0),
      nval, mls, mfs, 1'(mm)};
  endfunction

  function automatic obs_t rst_exp();
    return {1'b1, 1'b1, ~T0.hPol, ~T0.vPol,
      XW'(1), YW'(0), 1'b1, 1'b0,
      1'b0, 1'b0};
  endfunction

  task automatic check_vec(string name,
    obs_t got, obs_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h",
      name, got, want);
  endtask

  task automatic check_int(string name,
    int got, int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d",
      name, got, want);
  endtask

  task automatic check_period(string name,
    int idx, int want);
    if (fs_times.size() > idx + 1) begin
      check_int(name,
        fs_times[idx+1] - fs_times[idx], want);
    end else begin
      n_checks++;
      $display("FAIL %s: frameStart missing (seen %0d)",
        name, fs_times.size());
    end
  endtask

  task automatic model_reset();
    mh = 0;
    mv = 0;
    mm = 0;
    mls = 0;
    mfs = 0;
  endtask

  // Called at a falling edge: drive inputs, predict the
  // state after the coming rising edge, then move on.
  task automatic drive(bit p, bit m);
    pen = p;
    mode = m;
    mls = 0;
    mfs = 0;
    if (p) begin
      mh++;
      if (mh == ht(mm)) begin
        mh = 0;
        mv++;
        mls = 1;
        if (mv == vt(mm)) begin
          mv = 0;
          mfs = 1;
          mm = int'(m);
        end
      end
    end
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic do_reset(string name);
    rst_n = 1'b0;
    pen = 1'b0;
    model_reset();
    #1;
    check_vec(name, obs, rst_exp());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (frameStart) fs_times.push_back(cyc);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_vec($sformatf("sb@%0d", cyc), obs, e);
      end
    end
  end

  initial begin : stim
    int rel;
    int glitch_left;
    bit glitched;
    bit rmode;
    @(negedge clk);
    do_reset("reset_values");
    for (int i = 0; i < 10; i++) drive(1, 0);
    do_reset("midline_reset");
    fs_times.delete();
    rel = cyc;
    for (int i = 0; i < 2 * F0 + 5; i++)
      drive(1, 0);
    if (fs_times.size() > 0)
      check_int("first_frame",
        fs_times[0] - rel, F0);
    else check_int("first_frame", -1, F0);
    check_period("mode0_period", 0, F0);

    for (int i = 0; i < 100; i++) drive(1, 0);
    for (int i = 0; i < F0 + 2 * F1; i++)
      drive(1, 1);
    check_period("switch_keeps_mode0", 1, F0);
    check_period("mode1_period", 2, F1);

    for (int i = 0; i < F1 + 5; i++) drive(1, 0);
    fs_times.delete();
    glitch_left = 0;
    glitched = 0;
    for (int i = 0; i < 6 * F0; i++) begin
      if (!glitched && mv == 3) begin
        glitched = 1;
        glitch_left = 10;
      end
      drive(i % 2 == 0, glitch_left > 0);
      if (glitch_left > 0) glitch_left--;
    end
    check_period("half_rate_period", 0, 2 * F0);
    check_int("glitch_mode", int'(activeMode), 0);

    rmode = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0)
        rmode = ~rmode;
      if (i == 1500) do_reset("random_reset");
      drive($urandom_range(0, 3) != 0, rmode);
    end
    @(negedge clk);
    @(negedge clk);
    check_int("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed",
      n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised, glitch-free VGA timing generator that replaces the fixed 800x600 controller. It supports two runtime-selectable video modes, per-mode sync polarity and a pixel-clock enable, and provides one-pixel-lookahead coordinates plus line/frame strobes. It sits between the pixel clock domain and the frame-buffer read path and drives the DAC control pins directly.

## Interface
- `MODE0`, default `vga_pkg::SVGA_800x600_72` (800/56/120/64, 600/37/6/23, both pulses positive): timing selected when `Mode`=0.
- `MODE1`, default `vga_pkg::VGA_640x480_60` (640/16/96/48, 480/10/2/33, both pulses negative): timing selected when `Mode`=1.
- `X_WIDTH`, default 12: width of the horizontal counter and `nextX`.
- `Y_WIDTH`, default 11: width of the vertical counter and `nextY`.
- `Clock` in 1: pixel-domain clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `PixelEn` in 1: advance enable; the position moves only on cycles where it is 1.
- `Mode` in 1: requested mode; sampled only at frame wrap.
- `blank_n` out 1: 1 while the current position is in the active area.
- `sync_n` out 1: composite sync; 0 while either sync pulse is active, independent of polarity.
- `hSync_n` out 1: horizontal sync pin level; the pulse is high if the mode's `hPol`=1, otherwise low.
- `vSync_n` out 1: vertical sync pin level; same rule using `vPol`.
- `nextX` out X_WIDTH: column of the position one advance ahead; 0 if that position is blanked.
- `nextY` out Y_WIDTH: row of the position one advance ahead; 0 if that position is blanked.
- `nextValid` out 1: 1 if the lookahead position is active.
- `lineStart` out 1: one-Clock pulse when the position becomes `(0, v)`.
- `frameStart` out 1: one-Clock pulse when the position becomes `(0, 0)`.
- `activeMode` out 1: mode currently being generated.

## Operation
- **Counters.** Current position `(h, v)`. On a `PixelEn` cycle:
  - `h` increments; at `hTotal-1`, `h` wraps to 0.
  - On an `h` wrap, `v` increments; at `vTotal-1`, `v` wraps to 0.
  - Totals: `hTotal = disp+front+sync+back`, and likewise for `vTotal`.
- **Horizontal pulse region:** `disp+front <= h < disp+front+sync`. The vertical region uses the same rule on `v`. Active area: `h < hDisp && v < vDisp`.
- **Registered outputs.** All outputs are registers, computed from next-state position and mode, so they describe the current position with zero offset. There are no combinational output paths.
- **Lookahead.** `nextX`/`nextY`/`nextValid` describe the position one advance after the current one, including line and frame wrap. This feeds a 1-cycle-latency frame buffer.
- **Mode switching.**
  - `Mode` is sampled only on the advance from `(hTotal-1, vTotal-1)`.
  - The new mode applies from `(0,0)`; `activeMode` updates in the same cycle.
  - Changes to `Mode` at any other time have no effect until the next wrap.
- **Strobes when `PixelEn`=0.** The position holds, all level outputs hold, and `lineStart`/`frameStart` drop after one Clock.
- **Reset values.** Reset is asynchronous; outputs release on the first Clock edge after deassertion.
  - Position `(0,0)`, `activeMode`=0.
  - `blank_n`=1, `sync_n`=1, `hSync_n`/`vSync_n` at MODE0's inactive level.
  - `nextX`=1, `nextY`=0, `nextValid`=1.
  - `lineStart`=0, `frameStart`=0.
  - The first advance after reset does not raise any strobe.
- **Mid-frame reset.** Reset asserted mid-frame forces the reset values immediately (asynchronously). No partial frame completes and no strobe is generated.

## Timing
- **Generation latency:** 0 cycles from position to `blank_n`/sync, since these are registered alongside the counters.
- **Lookahead:** `nextX`/`nextY` lead `blank_n` by exactly one advance.
- **Frame period at `PixelEn`=1:**
  - MODE0: 1040×666 = 692 640 Clocks.
  - MODE1: 800×525 = 420 000 Clocks.
- **Within a line:**
  - `lineStart` rises in the Clock in which `h` becomes 0.
  - `frameStart` coincides with `lineStart` when `v` becomes 0.
- **MODE0 pulse positions:** `hSync_n` high for `h` in 856..975; `vSync_n` high for `v` in 637..642.

## Structure
- **`vga_pkg`** holds:
  - `typedef struct packed vga_timing_t` with fields `hDisp`, `hFront`, `hSync`, `hBack`, `vDisp`, `vFront`, `vSync`, `vBack` (12 bits each), plus `hPol` and `vPol` (1 bit each).
  - The constants `SVGA_800x600_72` and `VGA_640x480_60`.
  - Functions `hTotal()` and `vTotal()`.
- **Elaboration checks:** the top level asserts that both totals fit in `X_WIDTH`/`Y_WIDTH`.
- **Sub-module `vga_axis_counter`**, instantiated once per axis:
  - Inputs: enable, disp/front/sync/back for the selected mode, and `pol`.
  - Outputs: count, wrap, active, pulse level, and lookahead count/active.
  - The vertical instance is enabled by `PixelEn && hWrap`.

## Test plan
1. **Reset values:** assert `Reset_n`=0 mid-line, then release with `PixelEn`=1 → all reset values hold; the first `frameStart` occurs 692 640 Clocks after release.
2. **MODE0 free-run:** two frames with `PixelEn`=1 → `hSync_n`=1 exactly for `h` 856..975; `blank_n` falls at `h`=800 and rises at `h`=0 for `v`<600; the `frameStart` period is 692 640.
3. **Lookahead:**
   - At `(799,5)` → `nextValid`=0, `nextX`=0.
   - At `(1039,5)` → `nextX`=0, `nextY`=6, `nextValid`=1.
   - At `(1039,665)` → `nextX`=0, `nextY`=0, `nextValid`=1.
4. **Mode switch:** raise `Mode` at `(100,300)` → MODE0 timing continues to frame end; `activeMode`=1 from `(0,0)`; the next frame period is 420 000; `hSync_n` is low for `h` 656..751.
5. **PixelEn 50% duty:** toggle `PixelEn` every Clock → the frame period doubles to 1 385 280 Clocks; each strobe stays exactly one Clock wide.
6. **Mode glitch:** pulse `Mode` high for 10 Clocks mid-frame, then back low → `activeMode` stays 0 across the frame wrap.
